// File: rtl/ifid_pkg.sv
// Shared definitions for the IF/ID queue: MIPS opcode/funct codes, the decoded
// control word and the bubble constant.
// Optional feature macro: IFID_ILLEGAL_EN (flags undefined opcode/funct).
package ifid_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ALT  = 6'h2f;

    typedef struct packed {
        logic       ext_op;
        logic       lui_op;
        logic       branch;
        logic       mem_read;
        logic       mem_wr;
        logic       reg_wr;
        logic [3:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // R-type function codes the datapath implements; anything else is illegal
    function automatic logic funct_legal(input logic [5:0] funct);
        case (funct)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2a, 6'h2b, 6'h2f: funct_legal = 1'b1;
            default:             funct_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ifid_queue_if.sv
// Fetch/decode-facing signal bundle of the IF/ID queue.
// master: fetch + decode side; slave: the queue itself.
interface ifid_queue_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 2
);
    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [PC_W-1:0]              pc_in;
    logic [31:0]                  inst_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [PC_W-1:0]              pc_o;
    logic [31:0]                  inst_o;
    logic                         ExtOp;
    logic                         LuiOp;
    logic                         Branch;
    logic                         MemRead;
    logic                         MemWr;
    logic                         RegWr;
    logic [3:0]                   ALUOp;
    logic [1:0]                   ALUSrcA;
    logic [1:0]                   ALUSrc;
    logic [1:0]                   RegDst;
    logic [1:0]                   MemtoReg;
    logic [1:0]                   Jump;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         ill_inst;

    modport master (
        output flush, in_valid, pc_in, inst_in, out_ready,
        input  in_ready, out_valid, pc_o, inst_o, ExtOp, LuiOp, Branch, MemRead, MemWr,
               RegWr, ALUOp, ALUSrcA, ALUSrc, RegDst, MemtoReg, Jump, count, ill_inst
    );

    modport slave (
        input  flush, in_valid, pc_in, inst_in, out_ready,
        output in_ready, out_valid, pc_o, inst_o, ExtOp, LuiOp, Branch, MemRead, MemWr,
               RegWr, ALUOp, ALUSrcA, ALUSrc, RegDst, MemtoReg, Jump, count, ill_inst
    );

endinterface

// File: rtl/ifid_decode.sv
// Combinational MIPS main decoder: opcode/funct -> full control word.
// Optional feature macro: IFID_ILLEGAL_EN adds the ill output and zeroes the
// control word of undefined encodings.
module ifid_decode
    import ifid_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
`ifdef IFID_ILLEGAL_EN
    ,
    output logic       ill
`endif
);

    logic legal;

    // Decode one instruction; undefined opcodes fall through to the bubble word
    always_comb begin
        ctrl  = CTRL_NOP;
        legal = 1'b1;
        case (op)
            OP_RTYPE: begin
                ctrl.alu_op[2:0] = (funct == FN_ALT) ? 3'b111 : 3'b010;
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        ctrl.alu_src_a = 2'b11;
                        ctrl.reg_dst   = 2'b01;
                        ctrl.reg_wr    = 1'b1;
                    end
                    FN_JR: begin
                        ctrl.jump = 2'b10;
                    end
                    FN_JALR: begin
                        ctrl.jump      = 2'b10;
                        ctrl.reg_wr    = 1'b1;
                        ctrl.reg_dst   = 2'b01;
                        ctrl.alu_src_a = 2'b10;
                        ctrl.alu_src   = 2'b01;
                    end
                    default: begin
                        ctrl.reg_dst = 2'b01;
                        ctrl.reg_wr  = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.alu_src    = 2'b10;
                ctrl.ext_op     = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.reg_wr     = 1'b1;
                ctrl.mem_to_reg = 2'b01;
            end
            OP_SW: begin
                ctrl.alu_src = 2'b10;
                ctrl.ext_op  = 1'b1;
                ctrl.mem_wr  = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch      = 1'b1;
                ctrl.ext_op      = 1'b1;
                ctrl.alu_op[2:0] = 3'b001;
            end
            OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
                ctrl.branch = 1'b1;
                ctrl.ext_op = 1'b1;
            end
            OP_LUI: begin
                ctrl.alu_src = 2'b10;
                ctrl.ext_op  = 1'b1;
                ctrl.lui_op  = 1'b1;
                ctrl.reg_wr  = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI: begin
                ctrl.alu_src = 2'b10;
                ctrl.ext_op  = 1'b1;
                ctrl.reg_wr  = 1'b1;
                if (op == OP_ANDI) begin
                    ctrl.alu_op[2:0] = 3'b100;
                end else if (op != OP_ADDI) begin
                    ctrl.alu_op[2:0] = 3'b101;
                end
            end
            OP_ADDIU: begin
                ctrl.alu_src = 2'b10;
                ctrl.reg_wr  = 1'b1;
            end
            OP_J: begin
                ctrl.jump = 2'b01;
            end
            OP_JAL: begin
                ctrl.jump      = 2'b01;
                ctrl.reg_wr    = 1'b1;
                ctrl.reg_dst   = 2'b10;
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src   = 2'b01;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        // ALUOp[3] mirrors opcode bit 0 (inst[26]) for every defined opcode
        ctrl.alu_op[3] = legal & op[0];
`ifdef IFID_ILLEGAL_EN
        if (op == OP_RTYPE && !funct_legal(funct)) begin
            legal = 1'b0;
        end
        ill = ~legal;
        if (!legal) begin
            ctrl = CTRL_NOP;
        end
`endif
    end

endmodule

// File: rtl/ifid_queue.sv
// IF/ID pipeline queue: DEPTH-entry FIFO between fetch and decode with
// decode-on-write, valid/ready on both sides and synchronous flush.
// Optional feature macro: IFID_ILLEGAL_EN (per-entry illegal-instruction flag).
module ifid_queue
    import ifid_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 2
) (
    input logic         clk,
    input logic         reset,
    ifid_queue_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PC_W-1:0]  pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    ctrl_t            ctrl_mem_q [DEPTH];
    logic [PC_W-1:0]  last_pc_q;
    logic [31:0]      last_inst_q;

    logic  full;
    logic  empty;
    logic  push;
    logic  pop;
    ctrl_t dec_ctrl;
    ctrl_t head_ctrl;

    // No pass-through: a full queue refuses pushes even while popping
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.in_valid & ~full & ~bus.flush;
    assign pop   = ~empty & bus.out_ready & ~bus.flush;

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.count     = count_q;

`ifdef IFID_ILLEGAL_EN
    logic dec_ill;
    logic ill_mem_q [DEPTH];

    ifid_decode u_decode (
        .op   (bus.inst_in[31:26]),
        .funct(bus.inst_in[5:0]),
        .ctrl (dec_ctrl),
        .ill  (dec_ill)
    );

    // Illegal flag storage, written alongside the entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ill_mem_q[i] <= 1'b0;
            end
        end else if (push) begin
            ill_mem_q[wr_ptr_q] <= dec_ill;
        end
    end
`else
    ifid_decode u_decode (
        .op   (bus.inst_in[31:26]),
        .funct(bus.inst_in[5:0]),
        .ctrl (dec_ctrl)
    );
`endif

    // Pointer and occupancy update; flush dominates push and pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Entry storage: PC, raw instruction and its decoded control word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
                ctrl_mem_q[i] <= CTRL_NOP;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]   <= bus.pc_in;
            inst_mem_q[wr_ptr_q] <= bus.inst_in;
            ctrl_mem_q[wr_ptr_q] <= dec_ctrl;
        end
    end

    // Remember the most recent head so pc_o/inst_o hold while empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_pc_q   <= '0;
            last_inst_q <= '0;
        end else if (!empty) begin
            last_pc_q   <= pc_mem_q[rd_ptr_q];
            last_inst_q <= inst_mem_q[rd_ptr_q];
        end
    end

    // Head presentation; an empty queue shows a bubble
    always_comb begin
        head_ctrl    = CTRL_NOP;
        bus.pc_o     = last_pc_q;
        bus.inst_o   = last_inst_q;
        bus.ill_inst = 1'b0;
        if (!empty) begin
            head_ctrl  = ctrl_mem_q[rd_ptr_q];
            bus.pc_o   = pc_mem_q[rd_ptr_q];
            bus.inst_o = inst_mem_q[rd_ptr_q];
`ifdef IFID_ILLEGAL_EN
            bus.ill_inst = ill_mem_q[rd_ptr_q];
`endif
        end
    end

    assign bus.ExtOp    = head_ctrl.ext_op;
    assign bus.LuiOp    = head_ctrl.lui_op;
    assign bus.Branch   = head_ctrl.branch;
    assign bus.MemRead  = head_ctrl.mem_read;
    assign bus.MemWr    = head_ctrl.mem_wr;
    assign bus.RegWr    = head_ctrl.reg_wr;
    assign bus.ALUOp    = head_ctrl.alu_op;
    assign bus.ALUSrcA  = head_ctrl.alu_src_a;
    assign bus.ALUSrc   = head_ctrl.alu_src;
    assign bus.RegDst   = head_ctrl.reg_dst;
    assign bus.MemtoReg = head_ctrl.mem_to_reg;
    assign bus.Jump     = head_ctrl.jump;

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: directed scenarios plus randomized
// traffic against a queue-based reference model with a rule-based decoder.
module tb_ifid_queue;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ifid_queue_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    ifid_queue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t model_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word, assembled field by field from the decode rules.
    // Layout: {ExtOp,LuiOp,Branch,MemRead,MemWr,RegWr,ALUOp,ALUSrcA,ALUSrc,RegDst,MemtoReg,Jump}
    function automatic logic [19:0] ref_ctrl(input logic [31:0] inst);
        logic [5:0] op;
        logic [5:0] fn;
        logic rt, shf, jr, jalr, alu_r, lw, sw, br, lui, imm, addiu, j, jal;
        logic [3:0] alu;
        logic [1:0] srca, src, rdst, m2r, jmp;
        op = inst[31:26];
        fn = inst[5:0];
        rt = (op == 6'h00);
`ifdef IFID_ILLEGAL_EN
        if (rt && !(fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                               [6'h20:6'h27], 6'h2a, 6'h2b, 6'h2f})) return '0;
`endif
        shf   = rt && (fn inside {6'h00, 6'h02, 6'h03});
        jr    = rt && (fn == 6'h08);
        jalr  = rt && (fn == 6'h09);
        alu_r = rt && !shf && !jr && !jalr;
        lw    = (op == 6'h23);
        sw    = (op == 6'h2b);
        br    = (op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07});
        lui   = (op == 6'h0f);
        imm   = (op inside {6'h08, 6'h0a, 6'h0b, 6'h0c});
        addiu = (op == 6'h09);
        j     = (op == 6'h02);
        jal   = (op == 6'h03);
        if (!(rt || lw || sw || br || lui || imm || addiu || j || jal)) return '0;
        alu[3]   = inst[26];
        alu[2:0] = rt ? ((fn == 6'h2f) ? 3'b111 : 3'b010) :
                   (op == 6'h04) ? 3'b001 :
                   (op == 6'h0c) ? 3'b100 :
                   (op inside {6'h0a, 6'h0b}) ? 3'b101 : 3'b000;
        srca = shf ? 2'b11 : (jal || jalr) ? 2'b10 : 2'b00;
        src  = (lw || sw || lui || imm || addiu) ? 2'b10 : (jal || jalr) ? 2'b01 : 2'b00;
        rdst = (alu_r || shf || jalr) ? 2'b01 : jal ? 2'b10 : 2'b00;
        m2r  = lw ? 2'b01 : 2'b00;
        jmp  = (j || jal) ? 2'b01 : (jr || jalr) ? 2'b10 : 2'b00;
        return {lw | sw | br | lui | imm, lui, br, lw, sw,
                alu_r | shf | lw | lui | imm | addiu | jal | jalr,
                alu, srca, src, rdst, m2r, jmp};
    endfunction

    // Every defined encoding yields a nonzero control word, so all-zero means undefined
    function automatic logic ref_ill(input logic [31:0] inst);
`ifdef IFID_ILLEGAL_EN
        return ref_ctrl(inst) == '0;
`else
        return inst[0] & 1'b0;
`endif
    endfunction

    function automatic logic [19:0] obs_ctrl();
        return {bus.ExtOp, bus.LuiOp, bus.Branch, bus.MemRead, bus.MemWr, bus.RegWr,
                bus.ALUOp, bus.ALUSrcA, bus.ALUSrc, bus.RegDst, bus.MemtoReg, bus.Jump};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [5:0]  op;
        logic [5:0]  fn;
        r  = $urandom;
        op = r[31:26];
        case ($urandom_range(0, 19))
            0:  op = 6'h00;
            1:  op = 6'h01;
            2:  op = 6'h02;
            3:  op = 6'h03;
            4:  op = 6'h04;
            5:  op = 6'h05;
            6:  op = 6'h06;
            7:  op = 6'h07;
            8:  op = 6'h08;
            9:  op = 6'h09;
            10: op = 6'h0a;
            11: op = 6'h0b;
            12: op = 6'h0c;
            13: op = 6'h0f;
            14: op = 6'h23;
            15: op = 6'h2b;
            16: op = 6'h00;
            default: ;
        endcase
        fn = r[5:0];
        case ($urandom_range(0, 9))
            0: fn = 6'h00;
            1: fn = 6'h02;
            2: fn = 6'h03;
            3: fn = 6'h08;
            4: fn = 6'h09;
            5: fn = 6'h2f;
            default: ;
        endcase
        return {op, r[25:6], fn};
    endfunction

    task automatic check_state();
        int n;
        n = model_q.size();
        check_eq("count", 32'(bus.count), 32'(n));
        check_eq("in_ready", 32'(bus.in_ready), 32'(n < int'(DEPTH)));
        check_eq("out_valid", 32'(bus.out_valid), 32'(n > 0));
        if (n > 0) begin
            check_eq("pc_o", bus.pc_o, model_q[0].pc);
            check_eq("inst_o", bus.inst_o, model_q[0].inst);
            check_eq("ctrl", 32'(obs_ctrl()), 32'(ref_ctrl(model_q[0].inst)));
            check_eq("ill_inst", 32'(bus.ill_inst), 32'(ref_ill(model_q[0].inst)));
        end else begin
            check_eq("ctrl_bubble", 32'(obs_ctrl()), 32'h0);
            check_eq("ill_bubble", 32'(bus.ill_inst), 32'h0);
        end
    endtask

    // Drive one cycle from a negedge, advance the model, check at the next negedge
    task automatic cycle(input logic fl, input logic iv, input logic [31:0] pc,
                         input logic [31:0] inst, input logic ordy);
        logic do_push;
        logic do_pop;
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.pc_in     = pc;
        bus.inst_in   = inst;
        bus.out_ready = ordy;
        if (fl) begin
            model_q.delete();
        end else begin
            do_push = iv && (model_q.size() < int'(DEPTH));
            do_pop  = (model_q.size() > 0) && ordy;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back('{pc: pc, inst: inst});
        end
        @(negedge clk);
        check_state();
    endtask

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.pc_in     = '0;
        bus.inst_in   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_state();
        check_eq("rst_pc_o", bus.pc_o, 32'h0);
        check_eq("rst_inst_o", bus.inst_o, 32'h0);
        reset = 1'b0;

        // lw into empty queue appears after one edge
        cycle(1'b0, 1'b1, 32'h4, 32'h8C080004, 1'b0);
        check_eq("lw_out_valid", 32'(bus.out_valid), 32'h1);
        check_eq("lw_memread", 32'(bus.MemRead), 32'h1);
        check_eq("lw_memtoreg", 32'(bus.MemtoReg), 32'h1);
        check_eq("lw_alusrc", 32'(bus.ALUSrc), 32'h2);
        check_eq("lw_regwr", 32'(bus.RegWr), 32'h1);
        check_eq("lw_count", 32'(bus.count), 32'h1);

        // Fill, hold a third request, then pop without pass-through
        cycle(1'b0, 1'b1, 32'h8, 32'h0C000010, 1'b0);
        check_eq("full_count", 32'(bus.count), 32'h2);
        check_eq("full_in_ready", 32'(bus.in_ready), 32'h0);
        cycle(1'b0, 1'b1, 32'hC, 32'h00000000, 1'b0);
        cycle(1'b0, 1'b1, 32'hC, 32'h00000000, 1'b1);
        check_eq("pop_in_ready", 32'(bus.in_ready), 32'h1);
        check_eq("jal_jump", 32'(bus.Jump), 32'h1);
        check_eq("jal_regdst", 32'(bus.RegDst), 32'h2);
        check_eq("jal_alusrca", 32'(bus.ALUSrcA), 32'h2);
        check_eq("jal_alusrc", 32'(bus.ALUSrc), 32'h1);
        check_eq("jal_regwr", 32'(bus.RegWr), 32'h1);
        cycle(1'b0, 1'b1, 32'hC, 32'h00000000, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("sll_alusrca", 32'(bus.ALUSrcA), 32'h3);
        check_eq("sll_aluop", 32'(bus.ALUOp), 32'h2);

        // Flush while full with a push pending
        cycle(1'b0, 1'b1, 32'h10, 32'h20080001, 1'b0);
        check_eq("pre_flush_count", 32'(bus.count), 32'h2);
        cycle(1'b1, 1'b1, 32'h14, 32'h8C080004, 1'b1);
        check_eq("flush_count", 32'(bus.count), 32'h0);
        check_eq("flush_out_valid", 32'(bus.out_valid), 32'h0);
        check_eq("flush_ctrl", 32'(obs_ctrl()), 32'h0);

        // Back-to-back stream of 8 with consumer always ready
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 32'h100 + 32'(i) * 4, rand_inst(), 1'b1);
        end
        check_eq("stream_count", 32'(bus.count), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Undefined opcode
        cycle(1'b0, 1'b1, 32'h200, 32'hFC000000, 1'b0);
        check_eq("undef_ctrl", 32'(obs_ctrl()), 32'h0);
`ifdef IFID_ILLEGAL_EN
        check_eq("undef_ill", 32'(bus.ill_inst), 32'h1);
`else
        check_eq("undef_ill", 32'(bus.ill_inst), 32'h0);
`endif
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), $urandom,
                  rand_inst(), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset mid-operation clears without a clock edge
        cycle(1'b0, 1'b1, 32'h300, rand_inst(), 1'b0);
        cycle(1'b0, 1'b1, 32'h304, rand_inst(), 1'b0);
        reset = 1'b1;
        #1;
        model_q.delete();
        check_eq("async_rst_count", 32'(bus.count), 32'h0);
        check_eq("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
        check_eq("async_rst_pc_o", bus.pc_o, 32'h0);
        check_eq("async_rst_ctrl", 32'(obs_ctrl()), 32'h0);
        #1;
        reset = 1'b0;
        cycle(1'b0, 1'b1, 32'h400, 32'h3C01ABCD, 1'b1);
        cycle(1'b0, 1'b1, 32'h404, 32'hAC220008, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
